// File: rtl/boot_loader_arb_pkg.sv
// boot_pkg: shared state encoding and reply bytes for the boot loader
package boot_pkg;
  typedef enum logic [2:0] {LEN, LOAD, CHK, ACK, NAK, RUN} state_t;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;
endpackage

// File: rtl/boot_loader_arb_byte_assembler.sv
// byte_assembler: packs 4 bytes little-endian into a word; ports clk/rst/clr, byte_valid/byte_in in, word/word_valid out
module byte_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  cnt;
  logic [23:0] sr;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (byte_valid) cnt <= cnt + 2'd1;
    if (byte_valid) sr <= {byte_in, sr[23:8]};
  end
  // the 4th byte completes the word combinationally so the caller can act at the same edge
  assign word_valid = byte_valid && cnt == 2'd3;
  assign word = {byte_in, sr};
endmodule

// File: rtl/boot_loader_arb.sv
// boot_loader_arb: loads a checksummed image from the UART into imem, then passes the UART to the core; ports: UART FIFOs, core UART, imem write port, cpu_run
module boot_loader_arb
  import boot_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_empty,
  input  logic [7:0]        uart_in,
  output logic              uart_rdreq,
  output logic [7:0]        uart_out,
  output logic              uart_wrreq,
  input  logic              cpu_uart_rdreq,
  input  logic              cpu_uart_wrreq,
  input  logic [7:0]        cpu_uart_out,
  output logic              cpu_uart_empty,
  output logic [7:0]        cpu_uart_in,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run
);
  state_t          state;
  logic [ADDR_W:0] n, word_idx;
  logic [7:0]      sum;
  logic [31:0]     word;
  logic            word_valid, run, loading, take;
  assign run            = state == RUN;
  assign loading        = state == LEN || state == LOAD || state == CHK;
  assign take           = loading && !uart_empty;
  assign uart_rdreq     = run ? cpu_uart_rdreq : take;
  assign uart_wrreq     = run ? cpu_uart_wrreq : state == ACK || state == NAK;
  assign uart_out       = run ? cpu_uart_out : state == ACK ? ACK_BYTE : state == NAK ? NAK_BYTE : 8'h00;
  assign cpu_uart_empty = run ? uart_empty : 1'b1;
  assign cpu_uart_in    = run ? uart_in : 8'h00;
  // the checksum byte bypasses the assembler; NAK realigns it for the next image
  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (state == NAK),
    .byte_valid (take && state != CHK),
    .byte_in    (uart_in),
    .word       (word),
    .word_valid (word_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LEN;
      n          <= '0;
      word_idx   <= '0;
      sum        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        LEN: if (word_valid) begin
          word_idx <= '0;
          sum      <= '0;
          n        <= word[ADDR_W:0];
          state    <= word == 0 ? ACK : word > MAX_WORDS ? NAK : LOAD;
        end
        LOAD: begin
          if (take) sum <= sum + uart_in;
          if (word_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_idx[ADDR_W-1:0];
            imem_wdata <= word;
            word_idx   <= word_idx + 1'b1;
            if (word_idx + 1'b1 == n) state <= CHK;
          end
        end
        CHK: if (take) state <= uart_in == sum ? ACK : NAK;
        ACK: begin
          state   <= RUN;
          cpu_run <= 1'b1;
        end
        NAK: begin
          state    <= LEN;
          word_idx <= '0;
          sum      <= '0;
        end
        RUN: state <= RUN;
        default: state <= LEN;
      endcase
    end
  end
endmodule

// File: tb/tb_boot_loader_arb.sv
// tb_boot_loader_arb: randomized image loads checked against a byte-level model of the loader protocol
module tb_boot_loader_arb;
  localparam int ADDR_W = 12, MAX_WORDS = 4096;
  logic clk, rst, uart_empty, uart_rdreq, uart_wrreq, cpu_uart_rdreq, cpu_uart_wrreq;
  logic cpu_uart_empty, imem_we, cpu_run;
  logic [7:0] uart_in, uart_out, cpu_uart_out, cpu_uart_in;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0] imem_wdata;
  boot_loader_arb #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .uart_empty(uart_empty), .uart_in(uart_in), .uart_rdreq(uart_rdreq),
    .uart_out(uart_out), .uart_wrreq(uart_wrreq), .cpu_uart_rdreq(cpu_uart_rdreq),
    .cpu_uart_wrreq(cpu_uart_wrreq), .cpu_uart_out(cpu_uart_out), .cpu_uart_empty(cpu_uart_empty),
    .cpu_uart_in(cpu_uart_in), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  int tests, fails;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int cyc, pop_cyc, tx_cyc, run_cyc, viol;
  bit run_seen;
  logic [43:0] wr_q[$];
  logic [7:0]  tx_q[$];
  always @(posedge clk) begin
    cyc++;
    if (!rst && uart_rdreq && !uart_empty) pop_cyc = cyc;
    #1;
    if (!rst) begin
      if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
      if (uart_wrreq) begin
        tx_q.push_back(uart_out);
        tx_cyc = cyc;
      end
      if (cpu_run && !run_seen) begin
        run_seen = 1;
        run_cyc = cyc;
      end
    end
  end
  always @(negedge clk) begin
    #1;
    if (uart_empty && uart_rdreq) viol++;
  end
  logic [7:0]  img[$];
  logic [31:0] exp_w[$];
  // image = 4 length bytes, payload words little-endian, then payload byte sum mod 256 (+delta)
  task automatic make_image(input int delta);
    int s = 0;
    int nw = exp_w.size();
    img.delete();
    for (int b = 0; b < 4; b++) img.push_back(8'((nw >> (8 * b)) & 255));
    foreach (exp_w[i])
      for (int b = 0; b < 4; b++) begin
        img.push_back(8'((exp_w[i] >> (8 * b)) & 255));
        s += int'((exp_w[i] >> (8 * b)) & 255);
      end
    img.push_back(8'((s + delta) % 256));
  endtask
  task automatic rand_words(input int nw);
    exp_w.delete();
    for (int i = 0; i < nw; i++) exp_w.push_back($urandom());
  endtask
  task automatic send(input int gap);
    foreach (img[i]) begin
      @(negedge clk);
      while ($urandom_range(99) < gap) begin
        uart_empty = 1;
        @(negedge clk);
      end
      uart_empty = 0;
      uart_in = img[i];
    end
    @(negedge clk);
    uart_empty = 1;
  endtask
  task automatic expect_reply(input string tag, input logic [7:0] exp_tx, input int nw, input bit accept);
    int t = 0;
    logic [ADDR_W-1:0] a;
    while (tx_q.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({tag, "/tx_count"}, tx_q.size(), 1);
    if (tx_q.size() > 0) check({tag, "/tx_byte"}, tx_q[0], exp_tx);
    check({tag, "/tx_latency"}, tx_cyc, pop_cyc);
    check({tag, "/wr_count"}, wr_q.size(), nw);
    for (int i = 0; i < nw && i < wr_q.size(); i++) begin
      a = ADDR_W'(i);
      check({tag, "/wr"}, wr_q[i], {a, exp_w[i]});
    end
    check({tag, "/cpu_run"}, cpu_run, accept);
    if (accept) check({tag, "/run_latency"}, run_cyc, pop_cyc + 1);
    tx_q.delete();
    wr_q.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    uart_empty = 1;
    cpu_uart_rdreq = 0;
    cpu_uart_wrreq = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    wr_q.delete();
    tx_q.delete();
    run_seen = 0;
  endtask
  initial begin
    rst = 1;
    uart_empty = 1;
    uart_in = 0;
    cpu_uart_rdreq = 0;
    cpu_uart_wrreq = 0;
    cpu_uart_out = 0;
    do_reset();
    #1;
    check("rst/cpu_run", cpu_run, 0);
    check("rst/imem_we", imem_we, 0);
    check("rst/uart_wrreq", uart_wrreq, 0);
    check("rst/uart_rdreq", uart_rdreq, 0);
    check("rst/cpu_uart_empty", cpu_uart_empty, 1);
    uart_empty = 0;
    uart_in = 8'hAA;
    cpu_uart_wrreq = 1;
    cpu_uart_out = 8'h41;
    #1;
    check("len/rdreq", uart_rdreq, 1);
    check("len/cpu_empty", cpu_uart_empty, 1);
    check("len/cpu_in", cpu_uart_in, 0);
    check("len/core_tx_ignored", uart_wrreq, 0);
    uart_empty = 1;
    cpu_uart_wrreq = 0;
    do_reset();
    exp_w = '{32'h0000_0013, 32'hDEAD_BEEF};
    make_image(0);
    send(0);
    expect_reply("img_ok", 8'h06, 2, 1);
    do_reset();
    make_image(1);
    send(0);
    expect_reply("bad_chk", 8'h15, 2, 0);
    make_image(0);
    send(0);
    expect_reply("resend", 8'h06, 2, 1);
    do_reset();
    exp_w.delete();
    make_image(0);
    void'(img.pop_back());
    send(0);
    expect_reply("zero_len", 8'h06, 0, 1);
    do_reset();
    img = '{8'h01, 8'h10, 8'h00, 8'h00};
    send(0);
    expect_reply("too_long", 8'h15, 0, 0);
    rand_words($urandom_range(3, 5));
    make_image(0);
    send(20);
    expect_reply("after_nak", 8'h06, exp_w.size(), 1);
    do_reset();
    rand_words(8);
    make_image(0);
    send(50);
    expect_reply("gaps", 8'h06, 8, 1);
    do_reset();
    rand_words(3);
    make_image(0);
    img = img[0:8];
    send(0);
    do_reset();
    rand_words(3);
    make_image(0);
    send(10);
    expect_reply("mid_rst", 8'h06, 3, 1);
    @(negedge clk);
    cpu_uart_out = 8'h41;
    cpu_uart_wrreq = 1;
    uart_in = 8'h5A;
    uart_empty = 0;
    #1;
    check("run/uart_out", uart_out, 8'h41);
    check("run/uart_wrreq", uart_wrreq, 1);
    check("run/cpu_in", cpu_uart_in, 8'h5A);
    check("run/cpu_empty", cpu_uart_empty, 0);
    cpu_uart_rdreq = 1;
    #1;
    check("run/rdreq", uart_rdreq, 1);
    @(negedge clk);
    cpu_uart_wrreq = 0;
    cpu_uart_rdreq = 0;
    uart_empty = 1;
    #1;
    check("run/wrreq_low", uart_wrreq, 0);
    check("run/empty_follow", cpu_uart_empty, 1);
    check("run/cpu_run_held", cpu_run, 1);
    check("rd_while_empty", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
